dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Load/store unit between the MEM pipeline stage and the four byte-wide data-memory banks.
- Bank i (i=0..3) holds byte lane i. Byte address A maps to lane A[1:0] and word index A[ADDR_WIDTH-1:2].
- Splits stores into per-lane byte writes, issues per-lane reads, and handles the banks' 1-cycle registered read latency.
- Assembles load data with sign/zero extension and returns it on a valid-only response.

Parameters:
- ADDR_WIDTH, 8, byte-address width. Bank word-index width AW = ADDR_WIDTH-2.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  1 only in IDLE; transfer when REQ_VALID&&REQ_READY
- REQ_WE  in  1  1=store, 0=load
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
- REQ_UNSIGNED  in  1  zero-extend loads (LBU/LHU)
- REQ_ADDR  in  ADDR_WIDTH  byte address
- REQ_WDATA  in  32  store data, LSB-aligned
- RESP_VALID  out  1  one-cycle pulse: load data / store ack
- RESP_RDATA  out  32  extended load data; 0 for stores and errors
- RESP_ERR  out  1  valid with RESP_VALID; illegal size or unsupported misalignment
- BANK_ADDR  out  4*AW  lane i word index in bits [i*AW +: AW]; drives both bank W_ADDR and R_ADDR
- BANK_WE  out  4  per-lane write enable
- BANK_RE  out  4  per-lane read enable
- BANK_DIN  out  32  lane i write byte in bits [8i+7:8i]
- BANK_DOUT  in  32  lane i read byte; valid the cycle after BANK_RE[i]

Behaviour:
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE, on accept: register the request, go to ISSUE.
  - ISSUE: store goes to RESP; load goes to CAPTURE; error goes to RESP.
  - CAPTURE always goes to RESP. RESP always goes to IDLE.
- Accept at cycle T:
  - Bank enables are driven in T+1 only.
  - Store: RESP_VALID at T+2.
  - Load: BANK_DOUT is sampled at the end of T+2; RESP_VALID and RESP_RDATA at T+3.
  - Next accept no earlier than T+3 (store) or T+4 (load).
- Access bytes: n = 1/2/4. Byte k (k < n) is at address A+k, lane (A+k)[1:0], index (A+k)>>2 mod 2^AW.
  - Accesses at the top word wrap to index 0; no error is raised.
- Lanes not touched by the access have WE=RE=0. Their BANK_ADDR and BANK_DIN are don't-care, but held stable.
- Store: byte k of REQ_WDATA is placed on BANK_DIN of its lane. BANK_WE is set for touched lanes only. BANK_RE=0.
- Load: BANK_RE is set for touched lanes. Result byte k is taken from the lane of address A+k.
  - Signed byte: bits [31:8] copy bit 7. Signed half: bits [31:16] copy bit 15.
  - Unsigned byte/half: zero-extend.
  - Word: REQ_UNSIGNED is ignored.
- Error (REQ_SIZE=11, or misaligned without the option):
  - No bank enables, including no writes.
  - RESP_ERR=1, RESP_RDATA=0, same latency as a store.
- RESP_RDATA and RESP_ERR hold their last values when RESP_VALID=0. They are updated only when entering RESP.
- Reset values: state IDLE, REQ_READY=0 during the RST cycle, RESP_VALID=0, RESP_RDATA=0, RESP_ERR=0, BANK_WE=0, BANK_RE=0, BANK_ADDR=0, BANK_DIN=0.
- BANK_WE and BANK_RE are gated by !RST: no bank write occurs in any cycle with RST=1, even in ISSUE. Reset mid-operation drops the request with no response.
- REQ_* inputs are ignored outside the accept cycle.

Optional Feature:
- Macro: DMEM_LSU_MISALIGNED_EN.
- Defined: any alignment is legal. Misaligned half and word accesses complete in one ISSUE cycle using per-lane BANK_ADDR (lanes below the start offset use index+1). Latency is unchanged.
- Undefined: half with A[0]=1, or word with A[1:0]!=0, produces the error response. All accesses are single-word, so all touched lanes carry the same index.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10 -> T+1: BANK_WE=1111, all lanes index 4, BANK_DIN=0xDEADBEEF. T+2: RESP_VALID=1, RESP_ERR=0.
- Load word 0x10 -> T+1: BANK_RE=1111. T+3: RESP_RDATA=0xDEADBEEF, RESP_VALID high for exactly 1 cycle.
- Load byte 0x13, signed -> 0xFFFFFFDE. Load byte 0x13, unsigned -> 0x000000DE. Load half 0x12, signed -> 0xFFFFDEAD.
- Store byte 0x5A at 0x11 -> BANK_WE=0010, BANK_DIN[15:8]=0x5A. A following load word 0x10 -> 0xDEAD5AEF.
- Store word at 0x0E:
  - Without the macro -> BANK_WE=0000 throughout, RESP_ERR=1, RESP_RDATA=0.
  - With the macro and 0x11223344 -> lanes 2,3 at index 3, lanes 0,1 at index 4, WE=1111. A following load word 0x0E -> 0x11223344.
- Assert RST in the ISSUE cycle of a store -> BANK_WE=0 in that cycle, no RESP_VALID, memory unchanged. REQ_READY=1 the cycle after RST drops.

Source files
------------

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit driving four byte-lane data-memory banks
// Optional DMEM_LSU_MISALIGNED_EN: misaligned half/word accesses complete instead of erroring.
`timescale 1ns/1ps
module dmem_lsu #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic                        REQ_WE,
  input  logic [1:0]                  REQ_SIZE,
  input  logic                        REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0]       REQ_ADDR,
  input  logic [31:0]                 REQ_WDATA,
  output logic                        RESP_VALID,
  output logic [31:0]                 RESP_RDATA,
  output logic                        RESP_ERR,
  output logic [4*(ADDR_WIDTH-2)-1:0] BANK_ADDR,
  output logic [3:0]                  BANK_WE,
  output logic [3:0]                  BANK_RE,
  output logic [31:0]                 BANK_DIN,
  input  logic [31:0]                 BANK_DOUT
);

  localparam int AW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [1:0]            r_off;
  logic                  r_err;
  logic [3:0]            r_bank_we;
  logic [3:0]            r_bank_re;
  logic [3:0][AW-1:0]    r_bank_addr;
  logic [3:0][7:0]       r_bank_din;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic                  r_resp_err;

  logic                  w_accept;
  logic [1:0]            w_off;
  logic [AW-1:0]         w_idx;
  logic [AW-1:0]         w_idx_inc;
  logic [2:0]            w_nbytes;
  logic                  w_err;
  logic [3:0][1:0]       w_k;
  logic [3:0]            w_touch;
  logic [3:0][AW-1:0]    w_lane_idx;
  logic [3:0][7:0]       w_lane_din;
  logic [3:0][1:0]       w_sel;
  logic [3:0][7:0]       w_rot;
  logic [31:0]           w_ldata;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    REQ_READY = 1'b0;
    case (r_state)
      S_IDLE: begin
        REQ_READY = !RST;
        if (REQ_VALID && !RST) w_next = S_ISSUE;
      end
      S_ISSUE:   w_next = (r_we || r_err) ? S_RESP : S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_accept = REQ_VALID && REQ_READY;

  // Byte k of the access lands on lane (A+k)[1:0]; lanes below the start offset sit in the next word.
  always_comb begin
    w_off     = REQ_ADDR[1:0];
    w_idx     = REQ_ADDR[ADDR_WIDTH-1:2];
    w_idx_inc = w_idx + AW'(1);
    case (REQ_SIZE)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
`ifdef DMEM_LSU_MISALIGNED_EN
    w_err = (REQ_SIZE == 2'b11);
`else
    w_err = (REQ_SIZE == 2'b11) ||
            (REQ_SIZE == 2'b01 && w_off[0]) ||
            (REQ_SIZE == 2'b10 && w_off != 2'b00);
`endif
    for (int l = 0; l < 4; l++) begin
      w_k[l]        = 2'(l) - w_off;
      w_touch[l]    = !w_err && ({1'b0, w_k[l]} < w_nbytes);
      w_lane_idx[l] = (2'(l) < r_off_dummy(w_off)) ? w_idx_inc : w_idx;
      w_lane_din[l] = REQ_WDATA[8*w_k[l] +: 8];
    end
  end

  function automatic logic [1:0] r_off_dummy(input logic [1:0] off);
    return off;
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_sel[k] = r_off + 2'(k);
      w_rot[k] = BANK_DOUT[8*w_sel[k] +: 8];
    end
    case (r_size)
      2'b00:   w_ldata = r_uns ? {24'd0, w_rot[0]} : {{24{w_rot[0][7]}}, w_rot[0]};
      2'b01:   w_ldata = r_uns ? {16'd0, w_rot[1], w_rot[0]}
                               : {{16{w_rot[1][7]}}, w_rot[1], w_rot[0]};
      default: w_ldata = w_rot;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_off        <= 2'b00;
      r_err        <= 1'b0;
      r_bank_we    <= '0;
      r_bank_re    <= '0;
      r_bank_addr  <= '0;
      r_bank_din   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      // Enables live for exactly the ISSUE cycle; untouched lanes keep their last addr/din.
      r_bank_we <= '0;
      r_bank_re <= '0;
      if (w_accept) begin
        r_we      <= REQ_WE;
        r_size    <= REQ_SIZE;
        r_uns     <= REQ_UNSIGNED;
        r_off     <= w_off;
        r_err     <= w_err;
        r_bank_we <= REQ_WE ? w_touch : 4'b0000;
        r_bank_re <= REQ_WE ? 4'b0000 : w_touch;
        for (int l = 0; l < 4; l++) begin
          if (w_touch[l]) begin
            r_bank_addr[l] <= w_lane_idx[l];
            if (REQ_WE) r_bank_din[l] <= w_lane_din[l];
          end
        end
      end
      r_resp_valid <= (w_next == S_RESP);
      if (r_state == S_ISSUE && (r_we || r_err)) begin
        r_resp_rdata <= '0;
        r_resp_err   <= r_err;
      end
      if (r_state == S_CAPTURE) begin
        r_resp_rdata <= w_ldata;
        r_resp_err   <= 1'b0;
      end
    end
  end

  assign BANK_WE    = r_bank_we & {4{!RST}};
  assign BANK_RE    = r_bank_re & {4{!RST}};
  assign BANK_ADDR  = r_bank_addr;
  assign BANK_DIN   = r_bank_din;
  assign RESP_VALID = r_resp_valid;
  assign RESP_RDATA = r_resp_rdata;
  assign RESP_ERR   = r_resp_err;

endmodule
